alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width; legal values are powers of two from 8 to 64.
REQ-002 SHALL provide parameter SHW, default $clog2(XLEN), shift-amount width taken from b.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, operation request.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request this cycle.
REQ-007 SHALL have port op, input, 5, operation code.
REQ-008 SHALL have ports a and b, input, XLEN each, signed-capable operands.
REQ-009 SHALL have port out_valid, output, 1, result available.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port result, output, XLEN, registered result.
REQ-012 SHALL have port zero, output, 1, high when result == 0.
REQ-013 SHALL have port busy, output, 1, high while an iterative operation is in progress.

Function
REQ-014 SHALL use this op encoding: 0 PASS(A), 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 MUL, 12 MULH, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; codes 18-31 SHALL behave as PASS.
REQ-015 SHALL accept a request on a rising edge where in_valid && in_ready, capturing op, a and b.
REQ-016 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-017 SHALL take ops 0-10 IDLE->DONE and raise out_valid one cycle after acceptance.
REQ-018 SHALL take ops 11-17 IDLE->BUSY, run exactly XLEN iteration cycles (shift-add multiply, restoring divide), then go to DONE; out_valid SHALL rise XLEN+1 cycles after acceptance.
REQ-019 SHALL hold busy high only in BUSY.
REQ-020 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready); acceptance in DONE SHALL retire the current result and start the new op in the same edge, giving back-to-back throughput of one simple op per cycle.
REQ-021 SHALL hold result, zero and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL leave DONE for IDLE when out_ready is high and no new request is accepted.
REQ-023 SHALL ignore in_valid while in BUSY; captured operands SHALL NOT change.
REQ-024 SHALL use only b[SHW-1:0] as the shift amount for SLL, SRL and SRA; SRA SHALL sign-fill.
REQ-025 SHALL output 1 or 0 for SLT (signed) and SLTU (unsigned), zero-extended to XLEN.
REQ-026 SHALL wrap ADD, SUB and MUL modulo 2^XLEN; MULH is the signed×signed upper XLEN bits; MULHU is the unsigned×unsigned upper XLEN bits.
REQ-027 SHALL on divide-by-zero return quotient all-ones and remainder = a, signed and unsigned, with full latency.
REQ-028 SHALL on signed overflow (a = most-negative, b = -1) return DIV = a and REM = 0, with full latency.
REQ-029 SHALL round signed DIV toward zero; REM sign SHALL follow the dividend.

Reset
REQ-030 SHALL on rstn low immediately force state IDLE, out_valid 0, busy 0, result 0, zero 1 and the iteration counter 0, including mid-BUSY; in_ready SHALL be 1 after reset.
REQ-031 SHALL produce no out_valid for an operation aborted by reset.

Verification (XLEN=32)
REQ-032 ADD a=0x7FFFFFFF, b=1, out_ready=1 -> result 0x80000000 one cycle later, zero=0; SUB 5-5 on the next cycle -> result 0, zero=1 on the following cycle.
REQ-033 SRA a=0x80000000, b=0x00000021 -> result 0xC0000000 (shift 1); SLT a=-1, b=1 -> 1; SLTU with the same operands -> 0.
REQ-034 MULH a=0x80000000, b=0x80000000 -> result 0x40000000, out_valid exactly 33 cycles after acceptance, busy high for 32 cycles, in_valid ignored meanwhile.
REQ-035 DIV a=7, b=0 -> 0xFFFFFFFF; REM a=7, b=0 -> 7; DIV a=0x80000000, b=-1 -> 0x80000000; REM a=-7, b=2 -> 0xFFFFFFFF.
REQ-036 Hold out_ready=0 for 5 cycles after a DIVU 100/7 completes -> result 14 held stable and in_ready=0; on out_ready=1 with a new ADD presented -> both complete back-to-back.
REQ-037 Assert rstn low 10 cycles into a DIV -> out_valid=0, busy=0, in_ready=1 immediately; no result for the aborted op; the next ADD completes normally.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU; single-cycle logic/arith ops, XLEN-cycle shift-add multiply and restoring divide.
module alu_mc #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;
    logic [4:0] op_r;
    logic [2*XLEN-1:0] acc, acc_n, prod;
    logic [XLEN-1:0] opd, mag_a, mag_b, simple, fin, quo, rem;
    logic [XLEN:0] msum, dtrial;
    logic [SHW-1:0] cnt, shamt;
    logic accept, iter, sop, sgn_a, sgn_b, neg_q, neg_r, dz, last;

    assign in_ready  = state == IDLE || (state == DONE && out_ready);
    assign out_valid = state == DONE;
    assign busy      = state == BUSY;
    assign zero      = result == '0;
    assign accept    = in_valid && in_ready;
    assign iter      = op >= 5'd11 && op <= 5'd17;
    assign sop       = op == 5'd12 || op == 5'd14 || op == 5'd16;
    assign sgn_a     = sop && a[XLEN-1];
    assign sgn_b     = sop && b[XLEN-1];
    assign mag_a     = sgn_a ? -a : a;
    assign mag_b     = sgn_b ? -b : b;
    assign last      = cnt == SHW'(XLEN - 1);
    assign shamt     = b[SHW-1:0];

    always_comb begin
        case (op)
            5'd1:    simple = a + b;
            5'd2:    simple = a - b;
            5'd3:    simple = a & b;
            5'd4:    simple = a | b;
            5'd5:    simple = a ^ b;
            5'd6:    simple = a << shamt;
            5'd7:    simple = a >> shamt;
            5'd8:    simple = $signed(a) >>> shamt;
            5'd9:    simple = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            5'd10:   simple = {{(XLEN-1){1'b0}}, a < b};
            default: simple = a;
        endcase
    end

    // Iterations run on magnitudes; signs are restored when the last step lands in result.
    always_comb begin
        msum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
        dtrial = acc[2*XLEN-1:XLEN-1] - {1'b0, opd};
        acc_n  = op_r <= 5'd13 ? {msum, acc[XLEN-1:1]}
               : dtrial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
               : {dtrial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        prod   = neg_q ? -acc_n : acc_n;
        quo    = acc_n[XLEN-1:0];
        rem    = acc_n[2*XLEN-1:XLEN];
        case (op_r)
            5'd11:   fin = prod[XLEN-1:0];
            5'd12:   fin = prod[2*XLEN-1:XLEN];
            5'd13:   fin = acc_n[2*XLEN-1:XLEN];
            5'd14:   fin = dz ? '1 : neg_q ? -quo : quo;
            5'd15:   fin = quo;
            5'd16:   fin = neg_r ? -rem : rem;
            default: fin = rem;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            BUSY:    state_n = last ? DONE : BUSY;
            default: state_n = accept ? (iter ? BUSY : DONE)
                             : (state == DONE && out_ready) ? IDLE : state;
        endcase
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else       state <= state_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result <= '0;
            cnt    <= '0;
            acc    <= '0;
            opd    <= '0;
            op_r   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else if (accept) begin
            op_r  <= op;
            acc   <= {{XLEN{1'b0}}, mag_a};
            opd   <= mag_b;
            neg_q <= sgn_a ^ sgn_b;
            neg_r <= sgn_a;
            dz    <= b == '0;
            cnt   <= '0;
            if (!iter) result <= simple;
        end else if (state == BUSY) begin
            acc <= acc_n;
            cnt <= cnt + 1'b1;
            if (last) result <= fin;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors for alu_mc checked against a transaction-level model and literal expectations.
module tb_alu_mc;
    logic        clk = 0, rstn = 0, in_valid = 0, out_ready = 1;
    logic        in_ready, out_valid, zero, busy;
    logic [4:0]  op = 0;
    logic [31:0] a = 0, b = 0, result;
    int          n_chk = 0, n_fail = 0;

    int          m_cnt = 0;
    bit          m_valid = 0, m_rdy, c_rdy;
    logic [31:0] m_res = 0, m_pend = 0;
    logic [31:0] lit_v[$];
    string       lit_n[$];
    logic [31:0] lv;
    string       ln;

    always #5 clk = ~clk;

    alu_mc #(.XLEN(32)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_iter(input logic [4:0] o);
        return o >= 5'd11 && o <= 5'd17;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, sp;
        logic [63:0] up;
        logic [31:0] r;
        bit ovf;
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        sp  = sx * sy;
        up  = {32'b0, x} * {32'b0, y};
        ovf = x == 32'h8000_0000 && y == 32'hffff_ffff;
        case (o)
            5'd1:    r = x + y;
            5'd2:    r = x - y;
            5'd3:    r = x & y;
            5'd4:    r = x | y;
            5'd5:    r = x ^ y;
            5'd6:    r = x << y[4:0];
            5'd7:    r = x >> y[4:0];
            5'd8:    r = 32'(sx >>> y[4:0]);
            5'd9:    r = {31'b0, sx < sy};
            5'd10:   r = {31'b0, x < y};
            5'd11:   r = up[31:0];
            5'd12:   r = sp[63:32];
            5'd13:   r = up[63:32];
            5'd14:   r = (y == 0) ? 32'hffff_ffff : ovf ? x : 32'(sx / sy);
            5'd15:   r = (y == 0) ? 32'hffff_ffff : x / y;
            5'd16:   r = (y == 0) ? x : ovf ? 32'h0 : 32'(sx % sy);
            5'd17:   r = (y == 0) ? x : x % y;
            default: r = x;
        endcase
        return r;
    endfunction

    // Transaction model: simple ops complete next cycle, iterative ops after 32 busy cycles.
    always @(posedge clk) begin
        if (rstn) begin
            m_rdy = (m_cnt == 0) && (!m_valid || out_ready);
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_valid = 1;
                    m_res   = m_pend;
                end
            end else if (in_valid && m_rdy) begin
                if (is_iter(op)) begin
                    m_cnt   = 32;
                    m_valid = 0;
                    m_pend  = ref_alu(op, a, b);
                end else begin
                    m_valid = 1;
                    m_res   = ref_alu(op, a, b);
                end
            end else if (m_valid && out_ready) m_valid = 0;
        end
    end

    always @(negedge rstn) begin
        m_cnt   = 0;
        m_valid = 0;
        m_res   = 0;
        lit_v.delete();
        lit_n.delete();
    end

    always @(negedge clk) begin
        c_rdy = (m_cnt == 0) && (!m_valid || out_ready);
        chk("in_ready", 32'(in_ready), 32'(c_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_cnt > 0));
        if (m_valid) begin
            chk("result", result, m_res);
            chk("zero", 32'(zero), 32'(m_res == 0));
        end
        if (out_valid && out_ready && lit_v.size() > 0) begin
            lv = lit_v.pop_front();
            ln = lit_n.pop_front();
            chk(ln, result, lv);
        end
    end

    task automatic send(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e, input string nm);
        bit r;
        int t;
        t = 0;
        op = o; a = x; b = y; in_valid = 1;
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            t++;
        end while (!r && t < 100);
        if (!r) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: not accepted within %0d cycles", nm, t);
        end else begin
            lit_v.push_back(e);
            lit_n.push_back(nm);
        end
        #1 in_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, t;
        chk("model_mulh", ref_alu(5'd12, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        chk("model_rem_neg", ref_alu(5'd16, 32'hffff_fff9, 32'd2), 32'hffff_ffff);
        chk("model_div_ovf", ref_alu(5'd14, 32'h8000_0000, 32'hffff_ffff), 32'h8000_0000);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", result, 0);
        chk("rst_zero", 32'(zero), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rstn = 1;
        @(posedge clk);
        #1;
        send(5'd1,  32'h7fff_ffff, 32'd1,         32'h8000_0000, "add_wrap");
        send(5'd2,  32'd5,         32'd5,         32'h0,         "sub_zero");
        send(5'd3,  32'hf0f0_ff00, 32'h0ff0_0ff0, 32'h00f0_0f00, "and");
        send(5'd4,  32'hf0f0_ff00, 32'h0ff0_0ff0, 32'hfff0_fff0, "or");
        send(5'd5,  32'hf0f0_ff00, 32'h0ff0_0ff0, 32'hff00_f0f0, "xor");
        send(5'd6,  32'd1,         32'h23,        32'h8,         "sll_mask");
        send(5'd7,  32'h8000_0000, 32'd4,         32'h0800_0000, "srl");
        send(5'd8,  32'h8000_0000, 32'h21,        32'hc000_0000, "sra_mask");
        send(5'd9,  32'hffff_ffff, 32'd1,         32'h1,         "slt");
        send(5'd10, 32'hffff_ffff, 32'd1,         32'h0,         "sltu");
        send(5'd0,  32'h1234_5678, 32'd9,         32'h1234_5678, "pass");
        send(5'd31, 32'hdead_beef, 32'd9,         32'hdead_beef, "op31_pass");
        send(5'd11, 32'hffff_ffff, 32'hffff_ffff, 32'h1,         "mul");
        send(5'd13, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, "mulhu");
        send(5'd12, 32'hffff_fffe, 32'd3,         32'hffff_ffff, "mulh_neg");
        send(5'd14, 32'd7,         32'd0,         32'hffff_ffff, "div_by0");
        send(5'd16, 32'd7,         32'd0,         32'd7,         "rem_by0");
        send(5'd14, 32'hffff_fff9, 32'd0,         32'hffff_ffff, "div_neg_by0");
        send(5'd16, 32'hffff_fff9, 32'd0,         32'hffff_fff9, "rem_neg_by0");
        send(5'd14, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, "div_ovf");
        send(5'd16, 32'h8000_0000, 32'hffff_ffff, 32'h0,         "rem_ovf");
        send(5'd16, 32'hffff_fff9, 32'd2,         32'hffff_ffff, "rem_neg");
        send(5'd14, 32'hffff_fff9, 32'd2,         32'hffff_fffd, "div_neg");
        send(5'd15, 32'd5,         32'd0,         32'hffff_ffff, "divu_by0");
        send(5'd17, 32'd100,       32'd7,         32'd2,         "remu");
        // MULH with junk requests held on in_valid while busy
        send(5'd12, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
        nb = 0;
        op = 5'd1; a = 32'd1; b = 32'd2; in_valid = 1;
        repeat (30) begin
            @(negedge clk);
            nb += 32'(busy);
        end
        in_valid = 0;
        repeat (10) begin
            @(negedge clk);
            nb += 32'(busy);
        end
        chk("mulh_busy_cycles", nb, 32);
        @(posedge clk);
        #1 out_ready = 0;
        send(5'd15, 32'd100, 32'd7, 32'd14, "divu_hold");
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 100);
        chk("divu_done_seen", 32'(out_valid), 1);
        repeat (5) begin
            chk("divu_hold_result", result, 32'd14);
            chk("divu_hold_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1;
        send(5'd1, 32'd2,  32'd3, 32'd5, "add_after_hold");
        send(5'd2, 32'd10, 32'd4, 32'd6, "sub_b2b");
        repeat (3) @(posedge clk);
        #1;
        send(5'd14, 32'd100, 32'd3, 32'd33, "div_aborted");
        repeat (10) @(posedge clk);
        #1 rstn = 0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_result", result, 0);
        chk("abort_zero", 32'(zero), 1);
        #1 rstn = 1;
        repeat (40) @(posedge clk);
        #1;
        send(5'd1, 32'd1, 32'd1, 32'd2, "add_after_abort");
        repeat (5) @(posedge clk);
        #1;
        chk("lit_queue_drained", lit_v.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
